rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-port arbiter/scheduler for the single-write-port register file in the ID stage.
//  Shares the write port between the in-order pipeline WB stage and the multi-cycle MDU.
//  The MDU side has a valid/ready handshake and a DEPTH-entry result FIFO.
//  A per-register scoreboard reports busy destinations so ID can stall dependent reads.
//  Drives reg_we/reg_addr_3/reg_write of the register file directly; all three are registered.
// PARAMETERS
//  DW          32  data width (matches `N+1)
//  AW          5   register address width (32 registers; r0 reads as zero)
//  DEPTH       2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive cycles FIFO may lose to WB before WB is held off
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  wb_valid    in   1   pipeline WB result present (no backpressure except wb_hold)
//  wb_addr     in   AW  pipeline WB destination
//  wb_data     in   DW  pipeline WB data
//  wb_hold     out  1   registered; pipeline must not present wb_valid this cycle
//  mdu_valid   in   1   MDU result valid
//  mdu_ready   out  1   FIFO not full (combinational from FIFO count)
//  mdu_addr    in   AW  MDU destination
//  mdu_data    in   DW  MDU data
//  issue_valid in   1   multi-cycle op issued to MDU this cycle
//  issue_addr  in   AW  its destination register
//  issue_ready out  1   ~busy[issue_addr] (combinational)
//  rd_addr_1   in   AW  ID read address 1
//  rd_addr_2   in   AW  ID read address 2
//  rd_busy_1   out  1   busy[rd_addr_1] (combinational)
//  rd_busy_2   out  1   busy[rd_addr_2] (combinational)
//  reg_we      out  1   register file write enable (registered)
//  reg_addr_3  out  AW  register file write address (registered)
//  reg_write   out  DW  register file write data (registered)
//  wb_drop_err out  1   registered one-cycle pulse: wb_valid seen while wb_hold=1
// BEHAVIOUR
//  Reset: reg_we=0, reg_addr_3=0, reg_write=0, wb_hold=0, wb_drop_err=0.
//         FIFO empty, all busy bits 0, starve counter 0.
//  Grant, evaluated each cycle:
//   - wb_hold=1 and FIFO non-empty: grant FIFO head. Any wb_valid is dropped; wb_drop_err fires.
//   - else wb_valid and wb_addr!=0: grant WB.
//   - else FIFO non-empty: grant FIFO head (pop).
//   - else no write.
//  The winner is registered; reg_we is high the following cycle (latency 1).
//  WB with wb_addr==0 is no request; reg_we stays 0.
//  MDU push on mdu_valid&mdu_ready. mdu_addr==0 entries are discarded, never queued.
//  Accept at edge t -> earliest reg_we in the cycle after edge t+1 (latency 2).
//  Simultaneous push and pop on a full FIFO: mdu_ready is 0, so no push; pop proceeds.
//  Pointers wrap modulo DEPTH; count is held separately to tell full from empty.
//  Scoreboard: issue_valid&issue_ready&issue_addr!=0 sets busy[issue_addr].
//   - The FIFO pop committing that address clears it.
//   - Same-cycle set and clear of one address: set wins.
//   - issue_valid while issue_ready=0 is ignored. One outstanding op per register.
//   - busy[0] is always 0.
//  Starvation: counter increments when FIFO non-empty and WB wins; it clears on any FIFO pop.
//   - At count==STARVE_MAX-1 with WB winning again: wb_hold=1 for the next cycle only.
//   - Counter saturates; it never wraps.
//  Reset mid-operation: FIFO contents and busy bits are lost; outputs return to reset values
//   immediately (async).
// TESTING
//  1 Reset: pulse rst_n low mid-transfer -> reg_we=0, mdu_ready=1, all rd_busy=0 at once.
//  2 WB only: wb r5=0xDEADBEEF -> next cycle reg_we=1, reg_addr_3=5, reg_write=0xDEADBEEF.
//    wb r0 -> reg_we=0.
//  3 Issue r7, then rd_addr_1=7 -> rd_busy_1=1 and issue_ready=0 for r7.
//    MDU r7=0x12 accepted -> written 2 cycles later; busy clears the same edge.
//  4 Collision: FIFO holds r3 and wb_valid every cycle -> after 4 WB wins, wb_hold=1 for 1 cycle.
//    r3 is written that cycle; wb_valid during hold -> wb_drop_err=1.
//  5 Full: 2 MDU results pushed while WB busy -> mdu_ready=0; third held until a pop.
//    Order is preserved.
//  6 Same-cycle pop of r9 and new issue to r9 -> busy[9] stays 1.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the register-file write arbiter and its neighbours:
// pipeline WB stage, MDU result path, MDU issue path, ID read-busy lookup
// and the register-file write port.
//
// Handshake semantics (MDU result path): a result transfers on a rising
// clock edge where mdu_valid and mdu_ready are both high; mdu_ready never
// depends on mdu_valid. The WB path has no ready; the pipeline must
// keep wb_valid low while wb_hold is high, otherwise the result is dropped.
interface rf_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_hold;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          issue_ready;
    logic [AW-1:0] rd_addr_1;
    logic [AW-1:0] rd_addr_2;
    logic          rd_busy_1;
    logic          rd_busy_2;
    logic          reg_we;
    logic [AW-1:0] reg_addr_3;
    logic [DW-1:0] reg_write;
    logic          wb_drop_err;

    // Environment side: pipeline, MDU, ID stage and register file.
    modport master (
        output wb_valid, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        output issue_valid, issue_addr,
        output rd_addr_1, rd_addr_2,
        input  wb_hold, mdu_ready, issue_ready,
        input  rd_busy_1, rd_busy_2,
        input  reg_we, reg_addr_3, reg_write, wb_drop_err
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  issue_valid, issue_addr,
        input  rd_addr_1, rd_addr_2,
        output wb_hold, mdu_ready, issue_ready,
        output rd_busy_1, rd_busy_2,
        output reg_we, reg_addr_3, reg_write, wb_drop_err
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the single-write-port register file. Shares the
// port between the in-order WB stage and the MDU result FIFO, keeps a
// per-register busy scoreboard for outstanding MDU ops, and holds WB off
// for one cycle when the FIFO has lost the port too many times in a row.
module rf_wb_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX);

    // Result FIFO storage; contents need no reset since count gates reads.
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [SW-1:0]   starve;

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          hold_q;
    logic          drop_q;

    logic          fifo_ne;
    logic          fifo_full;
    logic          push;
    logic          grant_wb;
    logic          grant_fifo;
    logic          issue_set;
    logic          hold_next;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign fifo_ne   = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // r0 results are swallowed at the FIFO input so they never cost a write slot.
    assign push      = bus.mdu_valid & ~fifo_full & (bus.mdu_addr != '0);
    assign issue_set = bus.issue_valid & bus.issue_ready & (bus.issue_addr != '0);

    assign bus.mdu_ready   = ~fifo_full;
    assign bus.issue_ready = ~busy[bus.issue_addr];
    assign bus.rd_busy_1   = busy[bus.rd_addr_1];
    assign bus.rd_busy_2   = busy[bus.rd_addr_2];
    assign bus.reg_we      = we_q;
    assign bus.reg_addr_3  = addr_q;
    assign bus.reg_write   = data_q;
    assign bus.wb_hold     = hold_q;
    assign bus.wb_drop_err = drop_q;

    // Pick this cycle's writer: a held-off WB forces the FIFO head, otherwise WB first.
    always_comb begin
        grant_wb   = 1'b0;
        grant_fifo = 1'b0;
        if (hold_q && fifo_ne) begin
            grant_fifo = 1'b1;
        end else if (bus.wb_valid && (bus.wb_addr != '0)) begin
            grant_wb = 1'b1;
        end else if (fifo_ne) begin
            grant_fifo = 1'b1;
        end
    end

    // Hold WB off next cycle when the FIFO is about to lose for the STARVE_MAX-th time.
    assign hold_next = grant_wb & fifo_ne & (starve == STARVE_LAST);

    // Scoreboard update: pop clears, issue sets, a same-cycle set overrides the clear.
    always_comb begin
        busy_next = busy;
        if (grant_fifo) begin
            busy_next[head_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_next[bus.issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // FIFO data write on accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.mdu_addr;
            fifo_data[wr_ptr] <= bus.mdu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, grant_fifo})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Busy scoreboard and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            starve <= '0;
        end else begin
            busy <= busy_next;
            if (grant_fifo) begin
                starve <= '0;
            end else if (grant_wb && fifo_ne && (starve != STARVE_SAT)) begin
                starve <= starve + SW'(1);
            end
        end
    end

    // Registered write port plus the hold and drop-error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            hold_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            we_q <= grant_wb | grant_fifo;
            if (grant_wb) begin
                addr_q <= bus.wb_addr;
                data_q <= bus.wb_data;
            end else if (grant_fifo) begin
                addr_q <= head_addr;
                data_q <= head_data;
            end
            hold_q <= hold_next;
            drop_q <= bus.wb_valid & hold_q;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios with literal expectations,
// plus a queue-based model checked against every output on each cycle.
module tb_rf_wb_arbiter;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rf_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    rf_wb_arbiter #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset defaults.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rd1   = 0;
    int rd2   = 0;

    // Model state: FIFO as queues, busy bit per register, starvation run length.
    logic [AW-1:0] m_addr_q [$];
    logic [DW-1:0] exp_q    [$];
    logic [31:0]   m_busy   = '0;
    int            m_starve = 0;
    logic          e_we     = 1'b0;
    logic          e_hold   = 1'b0;
    logic          e_drop   = 1'b0;
    logic [AW-1:0] e_addr   = '0;
    logic [DW-1:0] e_data   = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit            ne, g_wb, g_fifo, push, iss, new_hold;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        if (!rst_n) begin
            m_addr_q.delete();
            exp_q.delete();
            m_busy   = '0;
            m_starve = 0;
            e_we     = 1'b0;
            e_hold   = 1'b0;
            e_drop   = 1'b0;
            e_addr   = '0;
            e_data   = '0;
        end else begin
            ne     = (m_addr_q.size() != 0);
            push   = bus.mdu_valid && (m_addr_q.size() < DEPTH) && (bus.mdu_addr != 0);
            iss    = bus.issue_valid && !m_busy[bus.issue_addr] && (bus.issue_addr != 0);
            g_wb   = 1'b0;
            g_fifo = 1'b0;
            if (e_hold && ne) g_fifo = 1'b1;
            else if (bus.wb_valid && bus.wb_addr != 0) g_wb = 1'b1;
            else if (ne) g_fifo = 1'b1;
            e_drop   = bus.wb_valid && e_hold;
            new_hold = g_wb && ne && (m_starve == STARVE_MAX - 1);
            if (g_wb) begin
                e_we   = 1'b1;
                e_addr = bus.wb_addr;
                e_data = bus.wb_data;
            end else if (g_fifo) begin
                ha         = m_addr_q.pop_front();
                hd         = exp_q.pop_front();
                e_we       = 1'b1;
                e_addr     = ha;
                e_data     = hd;
                m_busy[ha] = 1'b0;
            end else begin
                e_we = 1'b0;
            end
            if (g_fifo) m_starve = 0;
            else if (g_wb && ne && m_starve < STARVE_MAX) m_starve++;
            if (iss) m_busy[bus.issue_addr] = 1'b1;
            if (push) begin
                m_addr_q.push_back(bus.mdu_addr);
                exp_q.push_back(bus.mdu_data);
            end
            e_hold = new_hold;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare process: every output against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            check("reg_we", bus.reg_we, e_we);
            check("reg_addr_3", bus.reg_addr_3, e_addr);
            check("reg_write", bus.reg_write, e_data);
            check("wb_hold", bus.wb_hold, e_hold);
            check("wb_drop_err", bus.wb_drop_err, e_drop);
            check("mdu_ready", bus.mdu_ready, m_addr_q.size() < DEPTH);
            check("issue_ready", bus.issue_ready, !m_busy[bus.issue_addr]);
            check("rd_busy_1", bus.rd_busy_1, m_busy[bus.rd_addr_1]);
            check("rd_busy_2", bus.rd_busy_2, m_busy[bus.rd_addr_2]);
        end
    end

    // Driver: apply one cycle of inputs just after the falling edge, return at the next one.
    task automatic step(input bit wv, input int wa, input logic [DW-1:0] wd,
                        input bit mv, input int ma, input logic [DW-1:0] md,
                        input bit iv, input int ia);
        #1;
        bus.wb_valid    = wv;
        bus.wb_addr     = AW'(wa);
        bus.wb_data     = wd;
        bus.mdu_valid   = mv;
        bus.mdu_addr    = AW'(ma);
        bus.mdu_data    = md;
        bus.issue_valid = iv;
        bus.issue_addr  = AW'(ia);
        bus.rd_addr_1   = AW'(rd1);
        bus.rd_addr_2   = AW'(rd2);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    int got [$];

    initial begin
        bit acc22;
        bit rdy;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.mdu_valid   = 1'b0;
        bus.mdu_addr    = '0;
        bus.mdu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_addr  = '0;
        bus.rd_addr_1   = '0;
        bus.rd_addr_2   = '0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check("rst reg_we", bus.reg_we, 0);
        check("rst reg_addr_3", bus.reg_addr_3, 0);
        check("rst reg_write", bus.reg_write, 0);
        check("rst wb_hold", bus.wb_hold, 0);
        check("rst wb_drop_err", bus.wb_drop_err, 0);
        check("rst mdu_ready", bus.mdu_ready, 1);
        #1 rst_n = 1'b1;

        // WB only; r0 is no request.
        step(1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0);
        check("wb r5 we", bus.reg_we, 1);
        check("wb r5 addr", bus.reg_addr_3, 5);
        check("wb r5 data", bus.reg_write, 32'hDEADBEEF);
        step(1, 0, 32'h1234, 0, 0, '0, 0, 0);
        check("wb r0 we", bus.reg_we, 0);

        // MDU result to r0 is discarded.
        step(0, 0, '0, 1, 0, 32'h55, 0, 0);
        idle();
        check("mdu r0 we", bus.reg_we, 0);

        // Issue r7, then MDU result written two cycles after acceptance.
        rd1 = 7;
        step(0, 0, '0, 0, 0, '0, 1, 7);
        check("r7 busy", bus.rd_busy_1, 1);
        check("r7 issue_ready", bus.issue_ready, 0);
        step(0, 0, '0, 1, 7, 32'h12, 0, 7);
        check("r7 lat1 we", bus.reg_we, 0);
        check("r7 lat1 busy", bus.rd_busy_1, 1);
        idle();
        check("r7 we", bus.reg_we, 1);
        check("r7 addr", bus.reg_addr_3, 7);
        check("r7 data", bus.reg_write, 32'h12);
        check("r7 busy clr", bus.rd_busy_1, 0);

        // Asynchronous reset with a queued result and a busy register.
        rd1 = 4;
        step(0, 0, '0, 0, 0, '0, 1, 4);
        step(1, 6, 32'h66, 1, 4, 32'h44, 0, 0);
        check("pre-rst we", bus.reg_we, 1);
        check("pre-rst busy", bus.rd_busy_1, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst we", bus.reg_we, 0);
        check("async rst mdu_ready", bus.mdu_ready, 1);
        check("async rst busy", bus.rd_busy_1, 0);
        check("async rst addr", bus.reg_addr_3, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle();
        check("post-rst fifo lost", bus.reg_we, 0);

        // Starvation: FIFO holds r3 while WB wins four times, then a forced pop.
        rd1 = 3;
        step(0, 0, '0, 0, 0, '0, 1, 3);
        step(1, 10, 32'hA, 1, 3, 32'h33, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("starve no hold", bus.wb_hold, 0);
            step(1, 11 + i, DW'(i), 0, 0, '0, 0, 0);
        end
        check("starve hold", bus.wb_hold, 1);
        step(1, 15, 32'hF, 0, 0, '0, 0, 0);
        check("hold pop addr", bus.reg_addr_3, 3);
        check("hold pop data", bus.reg_write, 32'h33);
        check("hold drop_err", bus.wb_drop_err, 1);
        check("hold one cycle", bus.wb_hold, 0);
        check("r3 busy clr", bus.rd_busy_1, 0);
        idle();
        check("drop_err pulse", bus.wb_drop_err, 0);

        // Full FIFO under WB pressure; third result waits; order preserved.
        acc22 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.mdu_ready;
            if (i == 0) step(1, 11, 32'hB0, 1, 20, 32'hA0, 0, 0);
            else if (i == 1) step(1, 11, 32'hB1, 1, 21, 32'hA1, 0, 0);
            else if (!acc22) begin
                step(i < 6, 11, DW'(i), 1, 22, 32'hA2, 0, 0);
                acc22 = rdy;
            end else step(i < 6, 11, DW'(i), 0, 0, '0, 0, 0);
            if (i == 1) check("full mdu_ready", bus.mdu_ready, 0);
            if (bus.reg_we && bus.reg_addr_3 >= 20 && bus.reg_addr_3 <= 22)
                got.push_back(int'(bus.reg_addr_3));
        end
        check("order count", got.size(), 3);
        check("order 0", (got.size() > 0) ? got[0] : -1, 20);
        check("order 1", (got.size() > 1) ? got[1] : -1, 21);
        check("order 2", (got.size() > 2) ? got[2] : -1, 22);

        // Same-cycle pop of r9 and new issue to r9: set wins.
        rd1 = 9;
        rd2 = 9;
        step(0, 0, '0, 1, 9, 32'h99, 0, 0);
        step(0, 0, '0, 0, 0, '0, 1, 9);
        check("r9 pop addr", bus.reg_addr_3, 9);
        check("r9 busy kept 1", bus.rd_busy_1, 1);
        check("r9 busy kept 2", bus.rd_busy_2, 1);
        step(0, 0, '0, 1, 9, 32'h98, 0, 0);
        idle();
        check("r9 data", bus.reg_write, 32'h98);
        check("r9 busy clr", bus.rd_busy_1, 0);

        // r0 is never busy.
        rd1 = 0;
        step(0, 0, '0, 0, 0, '0, 1, 0);
        check("r0 busy", bus.rd_busy_1, 0);
        check("r0 issue_ready", bus.issue_ready, 1);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
